pdm_word_gen: RTL and testbench
===============================

Name: pdm_word_gen

Overview:
- Upstream feeder for the 16-bit PDM word serializer.
- Accepts signed 16-bit PCM samples over a valid/ready handshake and runs a first-order sigma-delta modulator, one bit per clk.
- Packs the bits MSB-first into 16-bit density words and buffers them in a small FIFO.
- Presents the head word to the serializer's din and pops it on each serializer done pulse.

Parameters:
- WORDS_PER_SAMPLE, 1, PDM words generated per accepted PCM sample (1..16).
- FIFO_DEPTH, 2, word buffer depth; power of two, >=2.
- IDLE_WORD, 16'h5555, word presented when the FIFO is empty (50% density, i.e. silence).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  block enable; low acts as a soft clear.
- pcm_data  in  16  signed two's-complement PCM sample.
- pcm_valid  in  1  pcm_data valid.
- pcm_ready  out  1  sample accepted when pcm_valid && pcm_ready.
- pdm_word  out  16  word to the serializer din.
- ser_en  out  1  enable to the serializer.
- ser_done  in  1  one-cycle pulse from the serializer; head word has been loaded and is finished with.
- underrun  out  1  one-cycle pulse: ser_done arrived while the FIFO was empty.
- fifo_level  out  clog2(FIFO_DEPTH)+1  current word count.

Behaviour:
- Reset (rst=1 at a clk edge), all outputs registered:
  - pcm_ready=0, ser_en=0, underrun=0, fifo_level=0, pdm_word=IDLE_WORD.
  - Accumulator=0, FSM=IDLE, FIFO empty.
- en is registered once (en_q). en_q=0 performs the same clear as rst, except ser_en simply follows en_q. ser_en = en_q, so it has 1 cycle latency from en.
- Modulator:
  - u = pcm_data ^ 16'h8000 (offset binary).
  - Each MOD cycle: {c, acc} = acc + u (17-bit sum). Output bit = c; acc keeps the low 16 bits.
  - acc is NOT cleared between samples or words, only by rst or en_q=0.
- Bit packing: the first generated bit lands in word bit 15; the shift register shifts left.
- FSM states and transitions:
  - IDLE: pcm_ready=1 iff en_q. On handshake, latch u, clear bit_cnt and word_cnt, go to MOD.
  - MOD: one bit per cycle for 16 cycles (bit_cnt 0..15). After bit 15, go to PUSH.
  - PUSH: if FIFO not full, write the word and increment word_cnt.
    - If word_cnt reaches WORDS_PER_SAMPLE, go to IDLE; else go back to MOD with the same u.
    - If the FIFO is full, stay in PUSH (stall; the word is held, no bits lost).
  - pcm_ready is low in MOD and PUSH.
- Output side:
  - pdm_word = FIFO head if level>0, else IDLE_WORD. It is registered and updated in the cycle after a push or pop.
  - ser_done with level>0 pops the FIFO.
  - ser_done with level==0 produces no pop and pulses underrun for 1 cycle.
  - Push and pop in the same cycle: both take effect and level is unchanged. When full, the push is still allowed only if a pop occurs in the same cycle.
  - pop on a FIFO holding 1 word with a simultaneous push: the new word becomes the head.
- Throughput: the serializer consumes 1 word per 400 clk (25 x 16), and generation takes 17 cycles per word. A full FIFO stall is therefore the normal steady state.
- Widths: all counters wrap-free by construction; fifo_level saturates at FIFO_DEPTH.

Decomposition:
- Package pdm_pkg holds:
  - PDM_WORD_W=16 and the IDLE_WORD default.
  - The FSM state enum {IDLE, MOD, PUSH}.
  - The offset-binary constant 16'h8000.
- One sub-module: pdm_word_fifo. It is a synchronous FIFO with parameters for width and depth, ports push/pop/full/empty/level, and head data exposed without a pop.

Test Plan:
- Midscale: after rst, en=1, pcm_data=16'h0000 -> first word 16'h5555; fifo_level goes 0->1 18 cycles after the handshake.
- Full scale: from reset, pcm_data=16'h7FFF -> word 16'h7FFF. Separately from reset, pcm_data=16'h8000 -> word 16'h0000.
- Three-quarter: from reset, pcm_data=16'h4000 -> word 16'h7777 (12/16 ones).
- Backpressure: FIFO_DEPTH=2, send 3 samples with no ser_done.
  - Required: fifo_level=2, FSM holds in PUSH, pcm_ready=0.
  - One ser_done -> third word is pushed the same cycle and fifo_level stays 2.
  - pdm_word sequence observed across pops matches the generation order.
- Underrun: empty FIFO, pulse ser_done -> underrun=1 for exactly 1 cycle, pdm_word stays 16'h5555, fifo_level stays 0.
- Mid-operation clear: deassert en (or assert rst) during MOD bit 7.
  - Next cycle after en_q=0: FIFO is empty, pdm_word=16'h5555, pcm_ready=0, ser_en=0.
  - Re-enable with 16'h4000 -> word 16'h7777 (accumulator was cleared).
  - With WORDS_PER_SAMPLE=2, the second word continues the accumulator sequence.

Source files
------------

// File: rtl/pdm_pkg.sv
// Shared constants and types for the PDM word generator.
//   PDM_WORD_W    : width of one PDM density word
//   PDM_IDLE_WORD : 50% density word (silence) shown while no word is buffered
//   PDM_OFFSET    : XOR mask turning two's-complement PCM into offset binary
//   pdm_state_e   : modulator sequencing states
package pdm_pkg;

   localparam int unsigned PDM_WORD_W = 16;

   localparam logic [PDM_WORD_W-1:0] PDM_IDLE_WORD = 16'h5555;
   localparam logic [PDM_WORD_W-1:0] PDM_OFFSET    = 16'h8000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MOD  = 2'd1,
      PUSH = 2'd2
   } pdm_state_e;

endpackage

// File: rtl/pdm_word_fifo.sv
// Small synchronous FIFO holding generated PDM words.
//   clk, rst  : clock, synchronous active-high clear
//   push      : write push_data (taken when not full, or when full with a pop)
//   push_data : word to write
//   pop       : drop the head word (ignored when empty)
//   head      : current head word, readable without popping
//   full      : level == DEPTH
//   empty     : level == 0
//   level     : current word count, 0..DEPTH
module pdm_word_fifo #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    count_q,  count_d;
   logic             do_push_c, do_pop_c;

   // A full FIFO still accepts a push when a pop frees the head slot in the same cycle.
   always_comb begin
      do_pop_c  = pop && (count_q != '0);
      do_push_c = push && ((count_q != LW'(DEPTH)) || do_pop_c);
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      if (do_push_c) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push_c, do_pop_c})
         2'b10:   count_d = count_q + LW'(1);
         2'b01:   count_d = count_q - LW'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and count registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; contents are only visible through count_q.
   always_ff @(posedge clk) begin
      if (do_push_c) mem_q[wr_ptr_q] <= push_data;
   end

   assign head  = mem_q[rd_ptr_q];
   assign full  = (count_q == LW'(DEPTH));
   assign empty = (count_q == '0);
   assign level = count_q;

endmodule

// File: rtl/pdm_word_gen.sv
// First-order sigma-delta modulator feeding the 16-bit PDM word serializer.
//   clk, rst   : clock, synchronous active-high reset
//   en         : block enable, registered once; low acts as a soft clear
//   pcm_data   : signed PCM sample, taken on pcm_valid && pcm_ready
//   pcm_valid  : pcm_data valid
//   pcm_ready  : generator idle and enabled
//   pdm_word   : buffered head word, or IDLE_WORD when the buffer is empty
//   ser_en     : serializer enable (registered copy of en)
//   ser_done   : serializer finished with the head word; pops it
//   underrun   : one-cycle pulse when ser_done finds the buffer empty
//   fifo_level : buffered word count
module pdm_word_gen
   import pdm_pkg::*;
#(
   parameter int unsigned            WORDS_PER_SAMPLE = 1,
   parameter int unsigned            FIFO_DEPTH       = 2,
   parameter logic [PDM_WORD_W-1:0]  IDLE_WORD        = PDM_IDLE_WORD
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   input  logic [PDM_WORD_W-1:0]         pcm_data,
   input  logic                          pcm_valid,
   output logic                          pcm_ready,
   output logic [PDM_WORD_W-1:0]         pdm_word,
   output logic                          ser_en,
   input  logic                          ser_done,
   output logic                          underrun,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned BIT_CNT_W  = 4;
   localparam int unsigned WORD_CNT_W = 5;

   pdm_state_e              state_q, state_d;
   logic                    en_q, en_d;
   logic [PDM_WORD_W-1:0]   acc_q, acc_d;
   logic [PDM_WORD_W-1:0]   u_q, u_d;
   logic [PDM_WORD_W-1:0]   sreg_q, sreg_d;
   logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic [WORD_CNT_W-1:0]   word_cnt_q, word_cnt_d;
   logic                    pcm_ready_q, pcm_ready_d;
   logic                    underrun_q, underrun_d;
   logic [PDM_WORD_W-1:0]   pdm_word_q, pdm_word_d;
   logic [LVL_W-1:0]        fifo_level_q, fifo_level_d;

   logic [PDM_WORD_W:0]     sum_c;
   logic                    push_c, pop_c, fifo_rst_c;
   logic [PDM_WORD_W-1:0]   fifo_head;
   logic                    fifo_full, fifo_empty;
   logic [LVL_W-1:0]        fifo_level_c;

   // Soft clear empties the buffer exactly like reset.
   assign fifo_rst_c = rst || !en_q;

   pdm_word_fifo #(
      .WIDTH (PDM_WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (fifo_rst_c),
      .push      (push_c),
      .push_data (sreg_q),
      .pop       (pop_c),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level_c)
   );

   // Next-state and output logic.
   always_comb begin
      state_d    = state_q;
      en_d       = en;
      acc_d      = acc_q;
      u_d        = u_q;
      sreg_d     = sreg_q;
      bit_cnt_d  = bit_cnt_q;
      word_cnt_d = word_cnt_q;
      push_c     = 1'b0;
      pop_c      = 1'b0;
      sum_c      = {1'b0, acc_q} + {1'b0, u_q};

      if (en_q) begin
         pop_c = ser_done && !fifo_empty;
         case (state_q)
            IDLE: begin
               if (pcm_valid && pcm_ready_q) begin
                  u_d        = pcm_data ^ PDM_OFFSET;
                  bit_cnt_d  = '0;
                  word_cnt_d = '0;
                  state_d    = MOD;
               end
            end
            MOD: begin
               // Carry out of the accumulator is the density bit; first bit ends up in bit 15.
               acc_d     = sum_c[PDM_WORD_W-1:0];
               sreg_d    = {sreg_q[PDM_WORD_W-2:0], sum_c[PDM_WORD_W]};
               bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
               if (bit_cnt_q == BIT_CNT_W'(PDM_WORD_W - 1)) state_d = PUSH;
            end
            PUSH: begin
               // Word is held in sreg_q until the buffer has room.
               if (!fifo_full || pop_c) begin
                  push_c     = 1'b1;
                  word_cnt_d = word_cnt_q + WORD_CNT_W'(1);
                  if ((word_cnt_q + WORD_CNT_W'(1)) == WORD_CNT_W'(WORDS_PER_SAMPLE)) begin
                     state_d = IDLE;
                  end else begin
                     bit_cnt_d = '0;
                     state_d   = MOD;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end else begin
         state_d    = IDLE;
         acc_d      = '0;
         u_d        = '0;
         sreg_d     = '0;
         bit_cnt_d  = '0;
         word_cnt_d = '0;
      end

      // Ready tracks the registered enable while idle.
      pcm_ready_d  = en && (state_d == IDLE);
      underrun_d   = en_q && ser_done && fifo_empty;
      fifo_level_d = en_q ? fifo_level_c : '0;
      pdm_word_d   = (en_q && !fifo_empty) ? fifo_head : IDLE_WORD;
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         en_q         <= 1'b0;
         acc_q        <= '0;
         u_q          <= '0;
         sreg_q       <= '0;
         bit_cnt_q    <= '0;
         word_cnt_q   <= '0;
         pcm_ready_q  <= 1'b0;
         underrun_q   <= 1'b0;
         pdm_word_q   <= IDLE_WORD;
         fifo_level_q <= '0;
      end else begin
         state_q      <= state_d;
         en_q         <= en_d;
         acc_q        <= acc_d;
         u_q          <= u_d;
         sreg_q       <= sreg_d;
         bit_cnt_q    <= bit_cnt_d;
         word_cnt_q   <= word_cnt_d;
         pcm_ready_q  <= pcm_ready_d;
         underrun_q   <= underrun_d;
         pdm_word_q   <= pdm_word_d;
         fifo_level_q <= fifo_level_d;
      end
   end

   assign pcm_ready  = pcm_ready_q;
   assign pdm_word   = pdm_word_q;
   assign ser_en     = en_q;
   assign underrun   = underrun_q;
   assign fifo_level = fifo_level_q;

endmodule

// File: tb/tb_pdm_word_gen.sv
// Bench for pdm_word_gen: instance a (1 word/sample, depth 2) and instance b (2 words/sample, depth 4).
module tb_pdm_word_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, en;
   logic [15:0] pcm_data;
   logic        a_valid, b_valid, a_done, b_done;
   logic        a_ready, b_ready, a_ser_en, b_ser_en, a_underrun, b_underrun;
   logic [15:0] a_word, b_word;
   logic [1:0]  a_level;
   logic [2:0]  b_level;

   int n_cmp = 0;
   int n_mis = 0;
   int acc_a, acc_b;
   logic [15:0] exp_a[$];
   logic [15:0] exp_b[$];

   pdm_word_gen #(.WORDS_PER_SAMPLE(1), .FIFO_DEPTH(2), .IDLE_WORD(16'h5555)) dut_a (
      .clk(clk), .rst(rst), .en(en), .pcm_data(pcm_data), .pcm_valid(a_valid),
      .pcm_ready(a_ready), .pdm_word(a_word), .ser_en(a_ser_en), .ser_done(a_done),
      .underrun(a_underrun), .fifo_level(a_level));

   pdm_word_gen #(.WORDS_PER_SAMPLE(2), .FIFO_DEPTH(4), .IDLE_WORD(16'h5555)) dut_b (
      .clk(clk), .rst(rst), .en(en), .pcm_data(pcm_data), .pcm_valid(b_valid),
      .pcm_ready(b_ready), .pdm_word(b_word), .ser_en(b_ser_en), .ser_done(b_done),
      .underrun(b_underrun), .fifo_level(b_level));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: offset-binary level added each bit time; overflow past 65536 emits a one.
   function automatic logic [15:0] model_word(input logic [15:0] pcm, inout int acc);
      int lvl;
      int w;
      lvl = int'($signed(pcm)) + 32768;
      w = 0;
      for (int i = 0; i < 16; i++) begin
         acc = acc + lvl;
         if (acc >= 65536) begin
            acc = acc - 65536;
            w = w * 2 + 1;
         end else begin
            w = w * 2;
         end
      end
      return 16'(w);
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; a_done = 1'b0; b_done = 1'b0;
      tick(2);
      rst = 1'b0;
      acc_a = 0; acc_b = 0;
      exp_a.delete(); exp_b.delete();
      tick(1);
   endtask

   // Called at a negedge; returns at the negedge right after the accepting edge.
   task automatic send(input bit to_b, input logic [15:0] d);
      int n;
      n = 0;
      pcm_data = d;
      if (to_b) b_valid = 1'b1; else a_valid = 1'b1;
      while (!(to_b ? b_ready : a_ready) && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("send_ready", 32'(to_b ? b_ready : a_ready), 32'd1);
      @(negedge clk);
      a_valid = 1'b0; b_valid = 1'b0;
      if (to_b) begin
         exp_b.push_back(model_word(d, acc_b));
         exp_b.push_back(model_word(d, acc_b));
      end else begin
         exp_a.push_back(model_word(d, acc_a));
      end
   endtask

   task automatic wait_level(input bit to_b, input int target, output int cyc);
      cyc = 0;
      while (int'(to_b ? b_level : a_level) != target && cyc < 300) begin
         @(negedge clk);
         cyc++;
      end
      check(to_b ? "b_level_wait" : "a_level_wait", 32'(to_b ? b_level : a_level), 32'(target));
   endtask

   // Compare the shown head with the model, then pulse ser_done and let pdm_word settle.
   task automatic pop(input bit to_b, input string tag);
      logic [15:0] e;
      e = 16'h5555;
      if (to_b) begin
         if (exp_b.size() > 0) e = exp_b.pop_front();
         check(tag, 32'(b_word), 32'(e));
         b_done = 1'b1;
      end else begin
         if (exp_a.size() > 0) e = exp_a.pop_front();
         check(tag, 32'(a_word), 32'(e));
         a_done = 1'b1;
      end
      @(negedge clk);
      a_done = 1'b0; b_done = 1'b0;
      @(negedge clk);
   endtask

   logic [15:0] dir_in  [3];
   logic [15:0] dir_exp [3];

   initial begin
      int cyc;
      int k;
      rst = 1'b1; en = 1'b0; pcm_data = '0;
      a_valid = 1'b0; b_valid = 1'b0; a_done = 1'b0; b_done = 1'b0;
      acc_a = 0; acc_b = 0;
      dir_in[0] = 16'h7FFF; dir_exp[0] = 16'h7FFF;
      dir_in[1] = 16'h8000; dir_exp[1] = 16'h0000;
      dir_in[2] = 16'h4000; dir_exp[2] = 16'h7777;
      tick(3);

      // Reset state
      check("rst_ready",    32'(a_ready),    32'd0);
      check("rst_ser_en",   32'(a_ser_en),   32'd0);
      check("rst_underrun", 32'(a_underrun), 32'd0);
      check("rst_level",    32'(a_level),    32'd0);
      check("rst_word",     32'(a_word),     32'h5555);
      check("rst_b_word",   32'(b_word),     32'h5555);
      check("rst_b_ser_en", 32'(b_ser_en),   32'd0);
      check("rst_b_unr",    32'(b_underrun), 32'd0);

      rst = 1'b0; en = 1'b1;
      tick(1);
      check("en_ser_en", 32'(a_ser_en), 32'd1);
      check("en_ready",  32'(a_ready),  32'd1);

      // Midscale: silence pattern and push latency
      do_reset();
      send(1'b0, 16'h0000);
      wait_level(1'b0, 1, cyc);
      check("mid_latency", 32'(cyc), 32'd18);
      check("mid_word", 32'(a_word), 32'h5555);
      pop(1'b0, "mid_pop");
      check("mid_level_after", 32'(a_level), 32'd0);
      check("mid_word_after",  32'(a_word),  32'h5555);

      // Full scale and three-quarter, each from reset
      for (int i = 0; i < 3; i++) begin
         do_reset();
         send(1'b0, dir_in[i]);
         wait_level(1'b0, 1, cyc);
         check("dir_word", 32'(a_word), 32'(dir_exp[i]));
         pop(1'b0, "dir_pop");
      end

      // Backpressure: three samples into a depth-2 buffer
      do_reset();
      for (int i = 0; i < 3; i++) send(1'b0, 16'($urandom));
      tick(40);
      check("bp_level",  32'(a_level), 32'd2);
      check("bp_ready",  32'(a_ready), 32'd0);
      tick(5);
      check("bp_hold",   32'(a_level), 32'd2);
      pop(1'b0, "bp_pop0");
      check("bp_level_after_pop", 32'(a_level), 32'd2);
      check("bp_ready_after_pop", 32'(a_ready), 32'd1);
      pop(1'b0, "bp_pop1");
      pop(1'b0, "bp_pop2");
      check("bp_level_empty", 32'(a_level), 32'd0);

      // Underrun on empty buffer
      a_done = 1'b1;
      @(negedge clk);
      a_done = 1'b0;
      check("unr_pulse", 32'(a_underrun), 32'd1);
      check("unr_word",  32'(a_word),     32'h5555);
      check("unr_level", 32'(a_level),    32'd0);
      @(negedge clk);
      check("unr_clear", 32'(a_underrun), 32'd0);

      // Soft clear during MOD bit 7 with one word already buffered
      do_reset();
      send(1'b0, 16'($urandom));
      wait_level(1'b0, 1, cyc);
      send(1'b0, 16'h4000);
      tick(7);
      en = 1'b0;
      tick(1);
      check("clr_ser_en", 32'(a_ser_en), 32'd0);
      check("clr_level_pre", 32'(a_level), 32'd1);
      tick(1);
      check("clr_level", 32'(a_level), 32'd0);
      check("clr_word",  32'(a_word),  32'h5555);
      check("clr_ready", 32'(a_ready), 32'd0);
      check("clr_ser_en2", 32'(a_ser_en), 32'd0);
      exp_a.delete(); acc_a = 0;
      en = 1'b1;
      tick(1);
      send(1'b0, 16'h4000);
      wait_level(1'b0, 1, cyc);
      check("clr_reenable_word", 32'(a_word), 32'h7777);
      pop(1'b0, "clr_pop");

      // Two words per sample: second word continues the accumulator
      do_reset();
      send(1'b1, 16'h1234);
      wait_level(1'b1, 2, cyc);
      pop(1'b1, "wps2_w0");
      pop(1'b1, "wps2_w1");
      check("wps2_empty", 32'(b_level), 32'd0);

      // Randomized traffic without reset, so the accumulator carries across samples
      for (int it = 0; it < 12; it++) begin
         k = int'($urandom_range(1, 2));
         for (int j = 0; j < k; j++) send(1'b0, 16'($urandom));
         wait_level(1'b0, k, cyc);
         tick(int'($urandom_range(0, 5)));
         for (int j = 0; j < k; j++) pop(1'b0, "rnd_a");
         if (($urandom & 32'd3) == 32'd0) begin
            send(1'b1, 16'($urandom));
            wait_level(1'b1, 2, cyc);
            pop(1'b1, "rnd_b0");
            pop(1'b1, "rnd_b1");
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
